// File: rtl/velocity_pkg.sv
// Shared types and constants for the velocity fragment path
// (ring node and cache writer).
package velocity_pkg;

   localparam int FRAG_W   = 96;
   localparam int NULL_BIT = 96;

   typedef enum logic [1:0] {IDLE, COLLECT, SWAP} state_e;

   // Emitted by the ring node on slots that carry no data
   localparam logic [FRAG_W:0] NULL_FRAG = {1'b1, {FRAG_W{1'b0}}};

endpackage

// File: rtl/velocity_bank_ram.sv
// One velocity cache bank: DEPTH x W.
// Synchronous write port and a registered read port.
module velocity_bank_ram #(
   parameter int DEPTH  = 256,
   parameter int ADDR_W = 8,
   parameter int W      = 96
) (
   input  logic              clk,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] waddr_i,
   input  logic [W-1:0]      wdata_i,
   input  logic [ADDR_W-1:0] raddr_i,
   output logic [W-1:0]      rdata_o
);

   logic [W-1:0] mem_q [DEPTH];
   logic [W-1:0] rdata_q;

   always_ff @(posedge clk) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
      rdata_q <= mem_q[raddr_i];
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/velocity_cache_writer.sv
// Captures non-null velocity fragments into the write bank of a double-buffered
// cache and swaps banks once the ring has been quiet for QUIET_SLOTS strobes.
module velocity_cache_writer
   import velocity_pkg::*;
#(
   parameter int DEPTH       = 256,
   parameter int ADDR_W      = $clog2(DEPTH),
   parameter int QUIET_SLOTS = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              phase_start,
   input  logic              frag_strobe,
   input  logic [FRAG_W:0]   fragment_in,
   input  logic [31:0]       addr_in,
   input  logic              ring_empty,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [FRAG_W-1:0] rd_data,
   output logic              busy,
   output logic              done,
   output logic [15:0]       particle_count,
   output logic              dup_err,
   output logic              addr_err
);

   localparam int QW = $clog2(QUIET_SLOTS + 1);

   state_e             state_q, state_d;
   logic               wbank_q, wbank_d;
   logic [DEPTH-1:0]   written_q, written_d;
   logic [15:0]        wcount_q, wcount_d;
   logic [QW-1:0]      quiet_q, quiet_d;
   logic [15:0]        pcount_q, pcount_d;
   logic               dup_q, dup_d;
   logic               aerr_q, aerr_d;
   logic               rsel_q, rvld_q;
   logic               wr_en;
   logic               is_null, in_range;
   logic [ADDR_W-1:0]  waddr;
   logic [1:0][FRAG_W-1:0] bank_rdata;

   assign is_null  = fragment_in[NULL_BIT];
   assign in_range = addr_in < 32'(DEPTH);
   assign waddr    = addr_in[ADDR_W-1:0];

   always_comb begin
      state_d   = state_q;
      wbank_d   = wbank_q;
      written_d = written_q;
      wcount_d  = wcount_q;
      quiet_d   = quiet_q;
      pcount_d  = pcount_q;
      dup_d     = dup_q;
      aerr_d    = aerr_q;
      wr_en     = 1'b0;
      case (state_q)
         IDLE: begin
            quiet_d  = '0;
            wcount_d = '0;
            if (phase_start) state_d = COLLECT;
         end
         COLLECT: begin
            if (frag_strobe) begin
               if (!is_null && in_range) begin
                  wr_en            = 1'b1;
                  written_d[waddr] = 1'b1;
                  if (written_q[waddr]) dup_d = 1'b1;
                  if (wcount_q != 16'hFFFF) wcount_d = wcount_q + 16'd1;
                  quiet_d = '0;
               end else if (!is_null) begin
                  aerr_d  = 1'b1;
                  quiet_d = '0;
               end else if (ring_empty) begin
                  quiet_d = quiet_q + 1'b1;
                  if (quiet_q == QW'(QUIET_SLOTS - 1)) state_d = SWAP;
               end else begin
                  quiet_d = '0;
               end
            end
         end
         SWAP: begin
            wbank_d   = ~wbank_q;
            written_d = '0;
            pcount_d  = wcount_q;
            state_d   = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         wbank_q   <= 1'b0;
         written_q <= '0;
         wcount_q  <= '0;
         quiet_q   <= '0;
         pcount_q  <= '0;
         dup_q     <= 1'b0;
         aerr_q    <= 1'b0;
         rsel_q    <= 1'b0;
         rvld_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         wbank_q   <= wbank_d;
         written_q <= written_d;
         wcount_q  <= wcount_d;
         quiet_q   <= quiet_d;
         pcount_q  <= pcount_d;
         dup_q     <= dup_d;
         aerr_q    <= aerr_d;
         // Select follows the pre-edge wbank so a read on the swap edge sees the old bank
         rsel_q    <= ~wbank_q;
         rvld_q    <= 32'(rd_addr) < 32'(DEPTH);
      end
   end

   for (genvar b = 0; b < 2; b++) begin : g_bank
      velocity_bank_ram #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .W(FRAG_W)) u_ram (
         .clk     (clk),
         .we_i    (wr_en && (wbank_q == 1'(b))),
         .waddr_i (waddr),
         .wdata_i (fragment_in[FRAG_W-1:0]),
         .raddr_i (rd_addr),
         .rdata_o (bank_rdata[b])
      );
   end

   assign rd_data        = rvld_q ? bank_rdata[rsel_q] : '0;
   assign busy           = (state_q == COLLECT);
   assign done           = (state_q == SWAP);
   assign particle_count = pcount_q;
   assign dup_err        = dup_q;
   assign addr_err       = aerr_q;

endmodule

// File: tb/tb_velocity_cache_writer.sv
// Directed and randomized checks of velocity_cache_writer against a
// two-buffer behavioural model of the cache.
module tb_velocity_cache_writer;
   import velocity_pkg::*;

   localparam int DEPTH = 256;
   localparam int AW    = 8;
   localparam int Q     = 4;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          phase_start = 1'b0;
   logic          frag_strobe = 1'b0;
   logic [96:0]   fragment_in = NULL_FRAG;
   logic [31:0]   addr_in = '0;
   logic          ring_empty = 1'b0;
   logic [AW-1:0] rd_addr = '0;
   logic [95:0]   rd_data;
   logic          busy, done, dup_err, addr_err;
   logic [15:0]   particle_count;

   velocity_cache_writer #(.DEPTH(DEPTH), .ADDR_W(AW), .QUIET_SLOTS(Q)) dut (
      .clk(clk), .reset(reset), .phase_start(phase_start), .frag_strobe(frag_strobe),
      .fragment_in(fragment_in), .addr_in(addr_in), .ring_empty(ring_empty),
      .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy), .done(done),
      .particle_count(particle_count), .dup_err(dup_err), .addr_err(addr_err)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Model: two buffers, one filling and one readable, swapped at phase end
   bit          m_collecting, m_swapping, m_dup, m_aerr, m_wb;
   int          m_quiet, m_cnt, m_pcount;
   logic [95:0] m_bank [2][DEPTH];
   bit          m_known[2][DEPTH];
   bit          m_written[DEPTH];

   task automatic chk(string tag, logic [95:0] got, logic [95:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_collecting = 0; m_swapping = 0; m_dup = 0; m_aerr = 0; m_wb = 0;
      m_quiet = 0; m_cnt = 0; m_pcount = 0;
      foreach (m_written[i]) m_written[i] = 0;
   endtask

   task automatic chk_outputs();
      chk("busy", busy, m_collecting);
      chk("done", done, m_swapping);
      chk("particle_count", particle_count, m_pcount);
      chk("dup_err", dup_err, m_dup);
      chk("addr_err", addr_err, m_aerr);
   endtask

   // One clock with the given inputs; model advances, outputs compared at negedge
   task automatic cyc(bit ps, bit fs, logic [96:0] f, logic [31:0] a, bit e, logic [AW-1:0] ra);
      logic [95:0] rexp;
      bit          rknown;
      phase_start = ps; frag_strobe = fs; fragment_in = f; addr_in = a;
      ring_empty = e; rd_addr = ra;
      rknown = m_known[!m_wb][ra];
      rexp   = m_bank[!m_wb][ra];
      if (m_swapping) begin
         m_wb = !m_wb;
         foreach (m_written[i]) m_written[i] = 0;
         m_pcount = m_cnt;
         m_swapping = 0;
      end else if (!m_collecting) begin
         m_quiet = 0; m_cnt = 0;
         if (ps) m_collecting = 1;
      end else if (fs) begin
         if (!f[96] && a < DEPTH) begin
            if (m_written[a]) m_dup = 1;
            m_written[a] = 1;
            m_bank[m_wb][a] = f[95:0];
            m_known[m_wb][a] = 1;
            if (m_cnt < 65535) m_cnt++;
            m_quiet = 0;
         end else if (!f[96]) begin
            m_aerr = 1; m_quiet = 0;
         end else if (e) begin
            m_quiet++;
            if (m_quiet == Q) begin m_collecting = 0; m_swapping = 1; end
         end else begin
            m_quiet = 0;
         end
      end
      @(negedge clk);
      phase_start = 0; frag_strobe = 0;
      chk_outputs();
      if (rknown) chk("rd_data", rd_data, rexp);
   endtask

   task automatic start();           cyc(1, 0, NULL_FRAG, 0, 0, rd_addr); endtask
   task automatic wr(int a, logic [95:0] d); cyc(0, 1, {1'b0, d}, a, 0, rd_addr); endtask
   task automatic nul(bit e);        cyc(0, 1, NULL_FRAG, 0, e, rd_addr); endtask
   task automatic idle(int n);       for (int i = 0; i < n; i++) cyc(0, 0, NULL_FRAG, 0, 0, rd_addr); endtask
   task automatic quiet4();          for (int i = 0; i < Q; i++) nul(1); endtask
   task automatic rd(int a, logic [95:0] exp);
      cyc(0, 0, NULL_FRAG, 0, 0, AW'(a));
      chk("rd_directed", rd_data, exp);
   endtask

   task automatic async_reset();
      #2 reset = 1'b0;
      #1;
      model_reset();
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_pcount", particle_count, 16'd0);
      chk("rst_dup", dup_err, 1'b0);
      chk("rst_aerr", addr_err, 1'b0);
      chk("rst_rd_data", rd_data, 96'h0);
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic basic_phase();
      start();
      wr(3, 96'h1);
      wr(7, 96'h2);
      for (int i = 0; i < Q - 1; i++) nul(1);
      chk("basic_no_early_done", done, 1'b0);
      nul(1);
      chk("basic_done", done, 1'b1);
      idle(1);
      chk("basic_pcount", particle_count, 16'd2);
      rd(3, 96'h1);
      rd(7, 96'h2);
   endtask

   initial begin
      model_reset();
      foreach (m_known[b, i]) m_known[b][i] = 0;
      #12;
      chk_outputs();
      chk("rst_rd_data", rd_data, 96'h0);
      @(negedge clk);
      reset = 1'b1;

      basic_phase();

      // Quiet run interrupted by a non-empty ring
      start();
      wr(10, 96'h3);
      for (int i = 0; i < 3; i++) nul(1);
      nul(0);
      for (int i = 0; i < 3; i++) nul(1);
      chk("quiet_not_yet", done, 1'b0);
      nul(1);
      chk("quiet_done_8th", done, 1'b1);
      idle(1);

      // Duplicate address: last write wins, both counted
      start();
      wr(5, 96'hA);
      wr(5, 96'hB);
      chk("dup_flag", dup_err, 1'b1);
      quiet4();
      idle(1);
      chk("dup_pcount", particle_count, 16'd2);
      rd(5, 96'hB);

      // Out-of-range address: flagged, not written, not counted
      start();
      wr(44, 96'h44);
      wr(300, 96'hDEAD);
      chk("aerr_flag", addr_err, 1'b1);
      quiet4();
      idle(1);
      chk("aerr_pcount", particle_count, 16'd1);
      rd(44, 96'h44);

      // Double buffering across two phases
      start();
      wr(0, 96'h11);
      quiet4();
      idle(1);
      rd(0, 96'h11);
      start();
      wr(0, 96'h22);
      rd(0, 96'h11);
      quiet4();
      rd(0, 96'h11);
      rd(0, 96'h22);

      // Reset in the middle of a phase, then a clean phase
      start();
      wr(9, 96'h99);
      async_reset();
      idle(1);
      basic_phase();

      // Randomized phases with stray phase_starts, bad addresses and gaps
      for (int p = 0; p < 8; p++) begin
         start();
         for (int s = 0; s < int'($urandom_range(30, 5)); s++) begin
            int          kind;
            bit          ps;
            logic [AW-1:0] ra;
            logic [95:0] d;
            kind = $urandom_range(11, 0);
            ps   = ($urandom_range(7, 0) == 0);
            ra   = AW'($urandom_range(15, 0));
            d    = {$urandom, $urandom, $urandom};
            if (kind <= 5)       cyc(ps, 1, {1'b0, d}, $urandom_range(15, 0), 0, ra);
            else if (kind == 6)  cyc(ps, 1, {1'b0, d}, $urandom_range(1000, 256), 0, ra);
            else if (kind <= 9)  cyc(ps, 1, NULL_FRAG, 0, 1'($urandom_range(1, 0)), ra);
            else                 cyc(ps, 0, NULL_FRAG, 0, 0, ra);
         end
         if (m_collecting) quiet4();
         idle(2);
         for (int a = 0; a < 16; a++) cyc(0, 0, NULL_FRAG, 0, 0, AW'(a));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/velocity_cache_writer.md
# velocity_cache_writer

Sits directly downstream of the velocity ring node. Captures each non-null velocity fragment the node emits for its cell and writes it into a double-buffered velocity cache at the carried particle address. Detects end-of-phase when the ring has gone quiet, then swaps banks. The freshly written bank becomes readable by the position-update stage for the next timestep.

## Interface
Parameters:
- DEPTH, 256, particle slots per bank.
- ADDR_W, 8, index width; $clog2(DEPTH).
- QUIET_SLOTS, 4, consecutive quiet strobes that end a phase.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- phase_start  in  1  one-cycle pulse that opens a velocity-collection phase.
- frag_strobe  in  1  one-cycle pulse per ring slot; fragment_in and addr_in are stable on this cycle.
- fragment_in  in  97  bit 96 = null flag (1 = no data); bits 95:0 = three 32-bit velocity components.
- addr_in  in  32  particle address within the cell.
- ring_empty  in  1  ring node has both queues empty.
- rd_addr  in  ADDR_W  read index into the read bank.
- rd_data  out  96  registered read data.
- busy  out  1  high in COLLECT.
- done  out  1  one-cycle pulse on bank swap.
- particle_count  out  16  writes accepted in the last completed phase; saturating.
- dup_err  out  1  sticky: same address written twice in one phase.
- addr_err  out  1  sticky: addr_in >= DEPTH on a non-null strobe.

## Operation
- State machine has three states: IDLE, COLLECT and SWAP.
- IDLE:
  - phase_start -> COLLECT.
  - Clear quiet counter and write counter.
  - Do not clear the error flags.
- COLLECT, on frag_strobe with fragment_in[96]==0 and addr_in<DEPTH:
  - Write fragment_in[95:0] to bank[wbank][addr_in].
  - Set written[addr_in].
  - Increment wcount, saturating at 16'hFFFF.
  - Reset the quiet counter.
  - If written[addr_in] was already set, set dup_err; the write still occurs, last write wins.
- COLLECT, on frag_strobe with non-null fragment and addr_in>=DEPTH: no write; set addr_err; reset the quiet counter.
- COLLECT, on frag_strobe with null fragment:
  - If ring_empty, increment the quiet counter; otherwise reset it.
  - When the counter reaches QUIET_SLOTS, go to SWAP.
- phase_start while in COLLECT or SWAP is ignored.
- SWAP lasts exactly one cycle, then returns to IDLE. In that cycle:
  - Toggle wbank.
  - Clear all written bits.
  - Load particle_count from wcount.
  - Assert done.
- Read port: rd_data <= bank[~wbank][rd_addr]. Out-of-range rd_addr returns 0.
- Reset (asynchronous, mid-operation included):
  - State -> IDLE, wbank=0.
  - written, counters, rd_data, busy, done, particle_count, dup_err and addr_err all -> 0.
  - RAM contents are not cleared.

## Timing
- Write latency: data written on the frag_strobe edge becomes readable only after the following SWAP. The first read is valid 1 cycle after rd_addr is presented, in the cycle after done.
- done is asserted in the SWAP cycle. That cycle is the clock after the strobe that took the quiet counter to QUIET_SLOTS.
- busy:
  - Rises the cycle after phase_start.
  - Falls in the SWAP cycle.
- rd_data latency is 1 cycle. If a read edge coincides with the SWAP edge, it returns the pre-swap read bank; the next read returns the new one.
- A frag_strobe in IDLE or SWAP is dropped and does not touch the counters.
- Strobes may arrive back-to-back; no throughput limit.

## Structure
- Package velocity_pkg holds:
  - FRAG_W=96, NULL_BIT=96;
  - the state enum {IDLE, COLLECT, SWAP};
  - the null-fragment constant {1'b1, 96'b0}, shared with the ring node.
- Sub-module velocity_bank_ram: simple dual-port RAM with DEPTH x 96, one synchronous write port and one registered read port. Instantiate it twice; select the bank by wbank.
- The written bit-vector, counters and FSM live in the top module.

## Test plan
- Basic phase:
  - Stimulus: reset; phase_start; strobes writing addr 3 = 96'h1, addr 7 = 96'h2; then 4 null strobes with ring_empty=1.
  - Response: done pulses once; particle_count=2; reading rd_addr 3 then 7 returns 96'h1 then 96'h2.
- Quiet interrupted:
  - Stimulus: 3 null/empty strobes, 1 null strobe with ring_empty=0, then 4 null/empty strobes.
  - Response: done only after the 8th strobe.
- Duplicate address:
  - Stimulus: addr 5 written with 96'hA then 96'hB in one phase.
  - Response: dup_err=1; after the swap, addr 5 reads 96'hB; particle_count=2.
- Bad address:
  - Stimulus: addr_in=300 with a non-null fragment.
  - Response: addr_err=1; no RAM write; particle_count unchanged.
- Double buffering:
  - Stimulus: phase 1 writes addr 0 = 96'h11; phase 2 writes addr 0 = 96'h22.
  - Response: between the two phases, addr 0 reads 96'h11. During phase 2 it still reads 96'h11. After phase 2's done it reads 96'h22.
- Async reset:
  - Stimulus: pulse reset low mid-COLLECT.
  - Response: busy, done, errors and particle_count go to 0 immediately; a subsequent phase behaves as in the basic-phase case.
